// File: rtl/uart_pkg.sv
// Shared UART definitions used by the AXI-Stream UART transmitter and receiver.
// Contents:
//   tx_state_t  - transmit FSM state encoding
//   count_speed - clock cycles per bit for a given clock and baud rate
//   frame_len   - bits per character frame (start + data + parity + stop)
//   cnt_width   - counter width able to hold 0..n-1, never zero bits wide
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int count_speed(input int clock, input int baud);
        return clock / baud;
    endfunction

    // The parity bit is always present, hence the fixed 2 (start + parity).
    function automatic int frame_len(input int data_bits, input int stop_bits);
        return 2 + data_bits + stop_bits;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream interface (tdata / tvalid / tready).
// Modports:
//   s_axis - sink side: tdata, tvalid in; tready out
//   m_axis - source side: tdata, tvalid out; tready in
interface axis_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport s_axis (input tdata, input tvalid, output tready);
    modport m_axis (output tdata, output tvalid, input tready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..COUNT_SPEED-1 while enabled and raises tick
// on the last count of each period, wrapping to 0 on that same edge.
// Ports:
//   clk_sys - clock
//   rst_b   - asynchronous active-low reset
//   en      - count enable
//   clr     - synchronous clear (wins over en)
//   tick    - high during the final cycle of a bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int COUNT_SPEED = 868
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(COUNT_SPEED);
    localparam logic [CW-1:0] LAST = CW'(COUNT_SPEED - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter. Each accepted word is split into
// AXI_DATA_WIDTH/DATA_BITS characters, most significant character first,
// each sent LSB first as start + data + parity + stop bit(s).
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset
//   uart_tx - registered serial line, idles high
//   tx_busy - high from word acceptance until the last stop bit ends
//   tx_done - one-cycle pulse after the last stop bit of a word
//   s_axis  - input word stream (tdata, tvalid, tready)
//
// state     | meaning
// ----------+-----------------------------------------------
// TX_IDLE   | line high, tready high, waiting for a word
// TX_START  | start bit (0)
// TX_DATA   | data bits of the current character, LSB first
// TX_PARITY | parity bit of the current character
// TX_STOP   | stop bit(s); chains to next character or idles
//
// All registered outputs are computed from the next state so that uart_tx,
// tready, tx_busy and tx_done line up with the state register: the start bit
// appears on the cycle right after the accepting handshake.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 0
) (
    input  logic   aclk,
    input  logic   aresetn,
    output logic   uart_tx,
    output logic   tx_busy,
    output logic   tx_done,
    axis_if.s_axis s_axis
);

    localparam int COUNT_SPEED = count_speed(CLOCK, BAUD_RATE);
    localparam int DATA_BYTE   = AXI_DATA_WIDTH / DATA_BITS;
    localparam int BIT_W       = cnt_width(DATA_BITS);
    localparam int STOP_W      = cnt_width(STOP_BITS);
    localparam int CHAR_W      = cnt_width(DATA_BYTE);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(DATA_BYTE - 1);

    tx_state_t state, next_state;

    logic [AXI_DATA_WIDTH-1:0] shift_buf, shift_buf_n;
    logic [BIT_W-1:0]          bit_cnt, bit_cnt_n;
    logic [STOP_W-1:0]         stop_cnt, stop_cnt_n;
    logic [CHAR_W-1:0]         char_cnt, char_cnt_n;
    logic                      parity_q, parity_n;
    logic                      tx_q, tx_n;
    logic                      ready_q, ready_n;
    logic                      busy_q, busy_n;
    logic                      done_q, done_n;

    logic [DATA_BITS-1:0]      cur_char, next_char;
    logic                      tick;
    logic                      running;
    logic                      accept;

    // The character on the wire always sits in the top DATA_BITS of the
    // buffer; the buffer shifts left once per finished character.
    assign cur_char  = shift_buf[AXI_DATA_WIDTH-1 -: DATA_BITS];
    assign next_char = shift_buf_n[AXI_DATA_WIDTH-1 -: DATA_BITS];
    assign running   = (state != TX_IDLE);
    assign accept    = s_axis.tvalid && ready_q;

    assign uart_tx       = tx_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign s_axis.tready = ready_q;

    uart_baud_gen #(
        .COUNT_SPEED (COUNT_SPEED)
    ) u_baud_gen (
        .clk_sys (aclk),
        .rst_b   (aresetn),
        .en      (running),
        .clr     (!running),
        .tick    (tick)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= TX_IDLE;
            shift_buf <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            char_cnt  <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= next_state;
            shift_buf <= shift_buf_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            char_cnt  <= char_cnt_n;
            parity_q  <= parity_n;
            tx_q      <= tx_n;
            ready_q   <= ready_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        next_state  = state;
        shift_buf_n = shift_buf;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        char_cnt_n  = char_cnt;
        parity_n    = parity_q;

        unique case (state)
            TX_IDLE: begin
                if (accept) begin
                    next_state  = TX_START;
                    shift_buf_n = s_axis.tdata;
                    char_cnt_n  = '0;
                end
            end
            TX_START: begin
                if (tick) begin
                    next_state = TX_DATA;
                    bit_cnt_n  = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        next_state = TX_PARITY;
                        // Captured from the buffer, not tdata, so later
                        // stream activity cannot disturb it.
                        parity_n   = (PARITY_BITS == 1) ? ^cur_char : ~^cur_char;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    next_state = TX_STOP;
                    stop_cnt_n = '0;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        if (char_cnt < CHAR_LAST) begin
                            next_state  = TX_START;
                            char_cnt_n  = char_cnt + CHAR_W'(1);
                            shift_buf_n = shift_buf << DATA_BITS;
                        end else begin
                            next_state = TX_IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + STOP_W'(1);
                    end
                end
            end
            default: next_state = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_n    = 1'b1;
        ready_n = (next_state == TX_IDLE);
        busy_n  = (next_state != TX_IDLE);
        done_n  = (state == TX_STOP) && (next_state == TX_IDLE);

        unique case (next_state)
            TX_IDLE:   tx_n = 1'b1;
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = next_char[bit_cnt_n];
            TX_PARITY: tx_n = parity_n;
            TX_STOP:   tx_n = 1'b1;
            default:   tx_n = 1'b1;
        endcase
    end

endmodule

// File: doc/axis_uart_tx.md
AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 8: AXI-Stream word width; an integer multiple of DATA_BITS.
REQ-002 SHALL have parameter CLOCK, default 100_000_000: aclk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115_200: line rate; COUNT_SPEED = CLOCK/BAUD_RATE cycles per bit.
REQ-004 SHALL have parameter DATA_BITS, default 8: data bits per UART character.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits per character.
REQ-006 SHALL have parameter PARITY_BITS, default 0: 1 = even parity (bit = XOR of data); 0 = odd parity (bit = inverted XOR). The parity bit is always sent.
REQ-007 SHALL have port aclk, input, 1: single clock; one clock only.
REQ-008 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port uart_tx, output, 1: serial line; idles high.
REQ-010 SHALL have port tx_busy, output, 1: high from word acceptance until the last stop bit ends.
REQ-011 SHALL have port tx_done, output, 1: one-cycle pulse after the last stop bit of a word.
REQ-012 SHALL have port s_axis, axis_if.s_axis, tdata AXI_DATA_WIDTH: input word stream (tdata, tvalid, tready).

Function
REQ-013 SHALL split each word into DATA_BYTE = AXI_DATA_WIDTH/DATA_BITS characters and send the most significant character first, LSB first within each character.
REQ-014 SHALL frame every character as: start (0) + DATA_BITS data + parity + STOP_BITS stop (1); each bit lasts exactly COUNT_SPEED cycles.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transition on baud counter = COUNT_SPEED-1.
REQ-016 IDLE: tready=1. On tvalid&tready, latch tdata into a shift buffer, drop tready, and go to START next cycle.
REQ-017 START -> DATA -> PARITY -> STOP. In STOP, on the last stop bit: if the character counter < DATA_BYTE-1, go to START with no idle gap; otherwise go to IDLE and pulse tx_done.
REQ-018 SHALL register uart_tx; the start bit's falling edge SHALL occur 1 cycle after the accepting handshake cycle.
REQ-019 SHALL compute parity over the character being sent at the start of the PARITY state, independent of later tdata changes.
REQ-020 SHALL hold tready low for the whole word; tvalid and tdata are ignored while busy.
REQ-021 SHALL assert tready in the same cycle the FSM returns to IDLE, so back-to-back words are separated by exactly 1 idle-high cycle.
REQ-022 SHALL size all counters with $clog2 and let them wrap only via explicit clears; no overflow for any legal parameter set.

Reset
REQ-023 On aresetn low, at any time including mid-frame, the block SHALL immediately return to IDLE with: uart_tx=1, tready=0, tx_busy=0, tx_done=0, all counters 0, buffer 0.
REQ-024 SHALL raise tready in the first aclk edge after reset release; a partially sent word is discarded, not resumed.

Structure
REQ-025 SHALL place the tx state enum and a COUNT_SPEED/frame-length helper function in shared package uart_pkg, which axis_uart_rx also uses.
REQ-026 SHALL contain one sub-module, uart_baud_gen: bit-period counter with a tick output and synchronous clear.

Verification (sim params CLOCK=1_000_000, BAUD_RATE=100_000 -> COUNT_SPEED=10)
REQ-027 SHALL cover single 8-bit word: send 0x55, PARITY_BITS=0 -> line reads 0,1,0,1,0,1,0,1,0,1(parity odd),1, each bit 10 cycles; tx_done at cycle 111.
REQ-028 SHALL cover a 16-bit word: send 0xA503 -> character 0xA5 is sent first, then 0x03, with no gap; PARITY_BITS=1 gives parity bits 0 then 0; exactly one tx_done.
REQ-029 SHALL cover back-to-back words: tvalid held high with 0x00 then 0xFF -> tready pulses exactly once per word; 1-cycle idle gap between words.
REQ-030 SHALL cover reset mid-frame: assert aresetn during the DATA state of 0x0F -> uart_tx=1 at once; next word 0x81 is sent correctly.
REQ-031 SHALL cover loopback: connect uart_tx to axis_uart_rx with matching params and 100 random words -> rx tdata equals tx tdata and rx_error stays 00.
